// File: rtl/pump_sequencer_if.sv
// Handshake/status bundle between the level-sensor front end, the operator
// controls and one pump_sequencer instance.
interface pump_sequencer_if;
  logic       level_low;
  logic       level_high;
  logic       enable;
  logic       fault_in;
  logic       clr_fault;
  logic       pump_pwm;
  logic       pump_on;
  logic [7:0] duty;
  logic [2:0] state;
  logic       fault_flag;

  modport master (
    output level_low, level_high, enable, fault_in, clr_fault,
    input  pump_pwm, pump_on, duty, state, fault_flag
  );

  modport slave (
    input  level_low, level_high, enable, fault_in, clr_fault,
    output pump_pwm, pump_on, duty, state, fault_flag
  );
endinterface

// File: rtl/pump_sequencer.sv
// Tank pump sequencer: debounced level sensors drive a start / ramp-up / run /
// ramp-down / lockout / fault FSM feeding a fixed-period PWM stage.
// Optional dry-run timeout is built when PUMP_DRYRUN_TIMEOUT_EN is defined.
module pump_sequencer #(
  parameter int unsigned PWM_PERIOD = 100,
  parameter int unsigned DUTY_MAX   = 100,
  parameter int unsigned RAMP_STEP  = 5,
  parameter int unsigned RAMP_DIV   = 1000,
  parameter int unsigned MIN_OFF    = 5000,
  parameter int unsigned DEB_LEN    = 16,
  parameter int unsigned MAX_RUN    = 1000000
) (
  input logic            clk,
  input logic            rst,
  pump_sequencer_if.slave bus
);

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned PCNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned LOCK_W = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;
  localparam int unsigned DEB_W  = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [DUTY_W-1:0] FIRST_T =
    DUTY_W'((RAMP_STEP < DUTY_MAX) ? RAMP_STEP : DUTY_MAX);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    LOCKOUT   = 3'd4,
    FAULT     = 3'd5
  } state_e;

  state_e              state_q;
  logic [DUTY_W-1:0]   target_q;
  logic [DUTY_W-1:0]   duty_q;
  logic [RDIV_W-1:0]   ramp_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [PCNT_W-1:0]   pwm_cnt;
  logic                pwm_q;
  logic                on_q;
  logic                flag_q;

  logic [1:0]          raw_c;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          db;
  logic [DEB_W-1:0]    deb_cnt [2];

  logic                low_db;
  logic                high_db;
  logic                conflict_c;
  logic                timeout_c;
  logic                fault_c;
  logic                stop_c;
  logic                start_c;
  logic                tick_c;
  logic                wrap_c;
  logic [DUTY_W:0]     up_sum_c;
  logic [DUTY_W:0]     dn_diff_c;
  logic [DUTY_W-1:0]   up_sat_c;
  logic [DUTY_W-1:0]   dn_sat_c;

  assign raw_c   = {bus.level_high, bus.level_low};
  assign low_db  = db[0];
  assign high_db = db[1];

  // Two-flop synchronizer plus run-length debouncer for both level sensors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_LEN - 1)) begin
            db[i]      <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef PUMP_DRYRUN_TIMEOUT_EN
  localparam int unsigned RUN_W = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
  logic [RUN_W-1:0] run_cnt;
  logic             pumping_c;
  logic             run_stay_c;

  assign pumping_c  = (state_q == RAMP_UP) || (state_q == RUN);
  assign run_stay_c = pumping_c && !fault_c && !stop_c;
  assign timeout_c  = pumping_c && (run_cnt == RUN_W'(MAX_RUN - 1));

  // Dry-run timer: counts while pumping without a stop, zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_cnt <= '0;
    else     run_cnt <= run_stay_c ? run_cnt + RUN_W'(1) : '0;
  end
`else
  logic unused_max_run;
  assign unused_max_run = (MAX_RUN != 0);
  assign timeout_c      = 1'b0;
`endif

  assign conflict_c = low_db & high_db;
  assign fault_c    = bus.fault_in | conflict_c | timeout_c;
  assign stop_c     = high_db | ~bus.enable;
  assign start_c    = bus.enable & low_db & ~high_db;
  assign tick_c     = (ramp_cnt == RDIV_W'(RAMP_DIV - 1));
  assign wrap_c     = (pwm_cnt == PCNT_W'(PWM_PERIOD - 1));

  // Nine-bit ramp arithmetic so saturation sees the carry/borrow
  assign up_sum_c  = {1'b0, target_q} + (DUTY_W + 1)'(RAMP_STEP);
  assign dn_diff_c = {1'b0, target_q} - (DUTY_W + 1)'(RAMP_STEP);
  assign up_sat_c  = (up_sum_c >= (DUTY_W + 1)'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX)
                                                           : up_sum_c[DUTY_W-1:0];
  assign dn_sat_c  = dn_diff_c[DUTY_W] ? '0 : dn_diff_c[DUTY_W-1:0];

  // Sequencing FSM: fault beats stop beats start; pump_on/fault_flag follow the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      ramp_cnt <= '0;
      lock_cnt <= '0;
      on_q     <= 1'b0;
      flag_q   <= 1'b0;
    end else if (state_q != FAULT && fault_c) begin
      state_q  <= FAULT;
      target_q <= '0;
      on_q     <= 1'b0;
      flag_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q  <= RAMP_UP;
            target_q <= FIRST_T;
            ramp_cnt <= '0;
            on_q     <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (stop_c) begin
            state_q  <= RAMP_DOWN;
            ramp_cnt <= '0;
          end else if (target_q == DUTY_W'(DUTY_MAX)) begin
            state_q <= RUN;
          end else if (tick_c) begin
            ramp_cnt <= '0;
            target_q <= up_sat_c;
          end else begin
            ramp_cnt <= ramp_cnt + RDIV_W'(1);
          end
        end
        RUN: begin
          if (stop_c) begin
            state_q  <= RAMP_DOWN;
            ramp_cnt <= '0;
          end
        end
        RAMP_DOWN: begin
          if (target_q == '0) begin
            state_q  <= LOCKOUT;
            lock_cnt <= '0;
            on_q     <= 1'b0;
          end else if (tick_c) begin
            ramp_cnt <= '0;
            target_q <= dn_sat_c;
          end else begin
            ramp_cnt <= ramp_cnt + RDIV_W'(1);
          end
        end
        LOCKOUT: begin
          if (lock_cnt == LOCK_W'(MIN_OFF - 1)) state_q <= IDLE;
          else                                  lock_cnt <= lock_cnt + LOCK_W'(1);
        end
        FAULT: begin
          if (bus.clr_fault && !bus.fault_in && !conflict_c) begin
            state_q  <= LOCKOUT;
            lock_cnt <= '0;
            flag_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= FAULT;
          target_q <= '0;
          on_q     <= 1'b0;
          flag_q   <= 1'b1;
        end
      endcase
    end
  end

  // PWM stage: duty reloads only at the period wrap; faults kill the drive at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pwm_cnt <= wrap_c ? '0 : pwm_cnt + PCNT_W'(1);
      if (fault_c || state_q == FAULT) begin
        duty_q <= '0;
        pwm_q  <= 1'b0;
      end else begin
        pwm_q <= (32'(pwm_cnt) < 32'(duty_q));
        if (wrap_c) duty_q <= target_q;
      end
    end
  end

  assign bus.pump_pwm   = pwm_q;
  assign bus.pump_on    = on_q;
  assign bus.duty       = duty_q;
  assign bus.state      = state_q;
  assign bus.fault_flag = flag_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Randomized + directed bench for pump_sequencer against a phase-based reference model.
module tb_pump_sequencer;

  localparam int PWM_PERIOD = 10;
  localparam int DUTY_MAX   = 10;
  localparam int RAMP_STEP  = 2;
  localparam int RAMP_DIV   = 20;
  localparam int MIN_OFF    = 50;
  localparam int DEB_LEN    = 4;
  localparam int MAX_RUN    = 500;
  localparam int H          = DEB_LEN + 1;

  logic clk = 1'b0;
  logic rst;
  pump_sequencer_if bus ();

  pump_sequencer #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_MAX   (DUTY_MAX),
    .RAMP_STEP  (RAMP_STEP),
    .RAMP_DIV   (RAMP_DIV),
    .MIN_OFF    (MIN_OFF),
    .DEB_LEN    (DEB_LEN),
    .MAX_RUN    (MAX_RUN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase + cycles-in-phase, target derived arithmetically
  int m_state, m_k, m_t0, m_duty, m_pwm, m_on, m_flag, m_pcnt, m_run;
  bit m_low_db, m_high_db;
  logic [H-1:0] lo_h, hi_h;

  function automatic int target_now();
    int t;
    case (m_state)
      1: begin
        t = RAMP_STEP * (1 + m_k / RAMP_DIV);
        if (t > DUTY_MAX) t = DUTY_MAX;
      end
      2: t = DUTY_MAX;
      3: begin
        t = m_t0 - RAMP_STEP * (m_k / RAMP_DIV);
        if (t < 0) t = 0;
      end
      default: t = 0;
    endcase
    return t;
  endfunction

  // A debounced value flips once the last DEB_LEN synchronized samples all disagree with it
  function automatic bit deb_next(input logic [H-1:0] h, input bit db);
    return (h[DEB_LEN:1] == {DEB_LEN{~db}}) ? ~db : db;
  endfunction

  task automatic model_reset();
    m_state = 0; m_k = 0; m_t0 = 0; m_duty = 0; m_pwm = 0;
    m_on = 0; m_flag = 0; m_pcnt = 0; m_run = 0;
    m_low_db = 0; m_high_db = 0; lo_h = '0; hi_h = '0;
  endtask

  task automatic model_edge(input bit lo, input bit hi, input bit ena, input bit fin, input bit clr);
    int cur_t, ns;
    bit conflict, stop, start, tmo, fault;
    cur_t    = target_now();
    conflict = m_low_db & m_high_db;
    stop     = m_high_db | !ena;
    start    = ena & m_low_db & !m_high_db;
    tmo      = 1'b0;
`ifdef PUMP_DRYRUN_TIMEOUT_EN
    tmo = (m_state == 1 || m_state == 2) && (m_run >= MAX_RUN - 1);
`endif
    fault = fin | conflict | tmo;
    ns = m_state;
    if (m_state != 5 && fault) ns = 5;
    else begin
      case (m_state)
        0: if (start) ns = 1;
        1: if (stop) begin ns = 3; m_t0 = cur_t; end
           else if (cur_t == DUTY_MAX) ns = 2;
        2: if (stop) begin ns = 3; m_t0 = DUTY_MAX; end
        3: if (cur_t == 0) ns = 4;
        4: if (m_k + 1 >= MIN_OFF) ns = 0;
        5: if (clr && !fin && !conflict) ns = 4;
        default: ns = 5;
      endcase
    end
    if (fault || m_state == 5) begin
      m_duty = 0;
      m_pwm  = 0;
    end else begin
      m_pwm = (m_pcnt < m_duty) ? 1 : 0;
      if (m_pcnt == PWM_PERIOD - 1) m_duty = cur_t;
    end
    m_pcnt = (m_pcnt + 1) % PWM_PERIOD;
    if ((m_state == 1 && (ns == 1 || ns == 2)) || (m_state == 2 && ns == 2)) m_run++;
    else m_run = 0;
    m_k     = (ns == m_state) ? m_k + 1 : 0;
    m_state = ns;
    m_on    = (ns >= 1 && ns <= 3) ? 1 : 0;
    m_flag  = (ns == 5) ? 1 : 0;
    m_low_db  = deb_next(lo_h, m_low_db);
    m_high_db = deb_next(hi_h, m_high_db);
    lo_h = {lo_h[H-2:0], lo};
    hi_h = {hi_h[H-2:0], hi};
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(bus.level_low, bus.level_high, bus.enable, bus.fault_in, bus.clr_fault);
    #1;
    check("state", int'(bus.state), m_state);
    check("duty", int'(bus.duty), m_duty);
    check("pump_pwm", int'(bus.pump_pwm), m_pwm);
    check("pump_on", int'(bus.pump_on), m_on);
    check("fault_flag", int'(bus.fault_flag), m_flag);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(bus.state) != s && n < budget) begin
      step();
      n++;
    end
    check(tag, int'(bus.state), s);
  endtask

  task automatic pulse_clr();
    bus.clr_fault = 1'b1;
    step();
    bus.clr_fault = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev, idx, lock_len, ones, pstate;
    rst = 1'b1;
    bus.level_low = 1'b0; bus.level_high = 1'b0; bus.enable = 1'b0;
    bus.fault_in = 1'b0; bus.clr_fault = 1'b0;
    model_reset();
    steps(2);
    check("reset_state", int'(bus.state), 0);
    check("reset_pwm", int'(bus.pump_pwm), 0);
    rst = 1'b0;

    // Start: demand accepted after DEB_LEN+2, RAMP_UP one edge later
    bus.enable = 1'b1; bus.level_low = 1'b1;
    steps(6);
    check("idle_before_start", int'(bus.state), 0);
    step();
    check("ramp_up_entry", int'(bus.state), 1);

    prev = 0; idx = 0;
    for (int i = 0; i < 150 && !(bus.state == 3'd2 && idx == 5); i++) begin
      step();
      if (int'(bus.duty) != prev) begin
        check("ramp_up_duty", int'(bus.duty), RAMP_STEP * (idx + 1));
        prev = int'(bus.duty);
        idx++;
      end
    end
    check("ramp_up_steps", idx, 5);
    wait_state(2, 20, "run_reached");
    steps(PWM_PERIOD);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ones += int'(bus.pump_pwm);
    end
    check("run_pwm_constant", ones, 20);

    // Ramp down on full tank, lockout ignores demand, then restart
    bus.level_low = 1'b0;
    steps(8);
    bus.level_high = 1'b1;
    prev = DUTY_MAX; idx = 0; lock_len = 0; pstate = int'(bus.state);
    for (int i = 0; i < 400; i++) begin
      step();
      if (int'(bus.duty) != prev) begin
        check("ramp_down_duty", int'(bus.duty), DUTY_MAX - RAMP_STEP * (idx + 1));
        prev = int'(bus.duty);
        idx++;
      end
      if (bus.state == 3'd4) lock_len++;
      if (bus.state == 3'd4 && lock_len == 10) begin
        bus.level_high = 1'b0;
        bus.level_low  = 1'b1;
      end
      if (pstate == 4 && bus.state != 3'd4) break;
      pstate = int'(bus.state);
    end
    check("ramp_down_steps", idx, 5);
    check("lockout_len", lock_len, MIN_OFF);
    check("idle_after_lockout", int'(bus.state), 0);
    step();
    check("restart", int'(bus.state), 1);

    // Short pulses rejected, long pulse accepted
    bus.enable = 1'b0;
    wait_state(4, 300, "disable_stop");
    bus.level_low = 1'b0;
    wait_state(0, 100, "back_idle");
    bus.enable = 1'b1;
    steps(10);
    bus.level_low = 1'b1; steps(3); bus.level_low = 1'b0;
    steps(20);
    check("short_pulse_ignored", int'(bus.state), 0);
    bus.level_low = 1'b1; steps(5); bus.level_low = 1'b0;
    wait_state(1, 10, "long_pulse_start");
    bus.level_low = 1'b1;

    // External fault in RUN
    wait_state(2, 200, "run_for_fault");
    steps(PWM_PERIOD);
    bus.fault_in = 1'b1;
    step();
    check("fault_state", int'(bus.state), 5);
    check("fault_pwm", int'(bus.pump_pwm), 0);
    check("fault_flag_set", int'(bus.fault_flag), 1);
    pulse_clr();
    check("clr_ignored", int'(bus.state), 5);
    steps(3);
    bus.fault_in = 1'b0;
    step();
    check("fault_holds", int'(bus.state), 5);
    pulse_clr();
    check("fault_to_lockout", int'(bus.state), 4);

    // Sensor conflict fault
    wait_state(1, 100, "restart_after_fault");
    bus.level_high = 1'b1;
    wait_state(5, 20, "conflict_fault");
    pulse_clr();
    check("conflict_clr_ignored", int'(bus.state), 5);
    bus.level_high = 1'b0;
    steps(8);
    pulse_clr();
    check("conflict_to_lockout", int'(bus.state), 4);

    // Async reset mid-ramp
    wait_state(1, 100, "ramp_for_reset");
    for (int i = 0; i < 40 && bus.pump_pwm != 1'b1; i++) step();
    check("pwm_high_before_reset", int'(bus.pump_pwm), 1);
    #2 rst = 1'b1;
    #1;
    check("async_pwm", int'(bus.pump_pwm), 0);
    check("async_state", int'(bus.state), 0);
    check("async_duty", int'(bus.duty), 0);
    check("async_on", int'(bus.pump_on), 0);
    model_reset();
    steps(2);
    rst = 1'b0;

    // Dry-run: demand held, tank never fills
    wait_state(1, 20, "dryrun_start");
`ifdef PUMP_DRYRUN_TIMEOUT_EN
    idx = 0;
    while (bus.state != 3'd5 && idx < MAX_RUN + 50) begin
      step();
      idx++;
    end
    check("dryrun_cycles", idx, MAX_RUN);
    bus.level_low = 1'b0;
    steps(8);
    pulse_clr();
    check("dryrun_clear", int'(bus.state), 4);
`else
    steps(MAX_RUN + 50);
    check("no_dryrun_timeout", int'(bus.state), 2);
`endif

    // Randomized operation
    for (int seg = 0; seg < 80; seg++) begin
      int r;
      int hold;
      r    = $urandom_range(0, 99);
      hold = $urandom_range(1, 40);
      if (r < 35)      bus.level_low  = ~bus.level_low;
      else if (r < 55) bus.level_high = ~bus.level_high;
      else if (r < 65) bus.enable     = ~bus.enable;
      else if (r < 75) bus.fault_in   = 1'b1;
      else if (r < 90) bus.clr_fault  = 1'b1;
      for (int c = 0; c < hold; c++) begin
        step();
        bus.clr_fault = 1'b0;
        if (c == 2) bus.fault_in = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
